// File: rtl/ahb_slave_sram_pkg.sv
// ahb_pkg: AHB bus encodings and the SRAM responder state encoding.
// The RETRY states exist only when AHB_SLAVE_RETRY_EN is defined.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  typedef enum logic [1:0] {
    HBURST_SINGLE = 2'd0,
    HBURST_INCR   = 2'd1
  } hburst_e;

  typedef enum logic [1:0] {
    HSIZE_BYTE  = 2'd0,
    HSIZE_HALF  = 2'd1,
    HSIZE_WORD  = 2'd2,
    HSIZE_DWORD = 2'd3
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
`ifdef AHB_SLAVE_RETRY_EN
    ,
    ST_RTY1 = 3'd5,
    ST_RTY2 = 3'd6
`endif
  } slv_state_e;

  // Contiguous byte-lane bits touched by a transfer of the given size,
  // before shifting to the address offset within the bus word.
  function automatic logic [7:0] size_lane_bits(input logic [1:0] hsize);
    case (hsize)
      2'd0:    size_lane_bits = 8'h01;
      2'd1:    size_lane_bits = 8'h03;
      2'd2:    size_lane_bits = 8'h0F;
      default: size_lane_bits = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_sram_if.sv
// AHB slave-side bus bundle for ahb_slave_sram.
// Handshake: an address phase is taken on a rising edge where hready,
// hsel and htrans[1] are all high; the data phase then ends on the first
// edge where the slave drives hready_out high. The master holds its next
// address phase stable while hready is low.
interface ahb_slave_sram_if
  import ahb_pkg::*;
#(
  parameter int BUS_WDT = 32
) ();
  logic               hsel;
  logic [31:0]        haddr;
  logic [1:0]         htrans;
  logic               hwrite;
  logic [1:0]         hsize;
  logic [1:0]         hburst;
  logic [BUS_WDT-1:0] hwdata;
  logic               hready;
  logic               retry_req;
  logic               hready_out;
  logic [1:0]         hresp;
  logic [BUS_WDT-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready, retry_req,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready, retry_req,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_sram_bank.sv
// ahb_sram_bank: DEPTH x BUS_WDT RAM, per-byte write enables, registered
// read port that holds its value when no read is requested.
module ahb_sram_bank
  import ahb_pkg::*;
#(
  parameter int BUS_WDT = 32,
  parameter int DEPTH   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_WDT/8-1:0]       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [BUS_WDT-1:0]         wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [BUS_WDT-1:0]         rdata
);
  localparam int NB = BUS_WDT / 8;

  logic [BUS_WDT-1:0] mem [DEPTH];
  logic [BUS_WDT-1:0] rdata_q, rdata_d;

  // Byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Read capture returns pre-write contents on a same-edge collision.
  always_comb begin
    rdata_d = re ? mem[raddr] : rdata_q;
  end

  // Read register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/ahb_slave_sram.sv
// ahb_slave_sram: AHB responder in front of an on-chip SRAM bank.
// Optional macro AHB_SLAVE_RETRY_EN adds the two-cycle RETRY response.
module ahb_slave_sram
  import ahb_pkg::*;
#(
  parameter int          BUS_WDT     = 32,
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic               i_hclk,
  input  logic               i_hreset,
  input  logic               i_hsel,
  input  logic [31:0]        i_haddr,
  input  logic [1:0]         i_htrans,
  input  logic               i_hwrite,
  input  logic [1:0]         i_hsize,
  input  logic [1:0]         i_hburst,
  input  logic [BUS_WDT-1:0] i_hwdata,
  input  logic               i_hready,
  input  logic               i_retry_req,
  output logic               o_hready,
  output logic [1:0]         o_hresp,
  output logic [BUS_WDT-1:0] o_hrdata,
  output logic [2:0]         o_dbg_state
);
  localparam int          NB        = BUS_WDT / 8;
  localparam int          OFFW      = $clog2(NB);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH * NB);

  slv_state_e         state_q, state_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic [AW-1:0]      addr_idx_q, addr_idx_d;
  logic [NB-1:0]      mask_q, mask_d;
  logic               write_q, write_d;
  logic [NB-1:0]      byp_mask_q, byp_mask_d;
  logic [BUS_WDT-1:0] byp_data_q, byp_data_d;

  logic [32:0]        rel_addr;
  logic               misaligned, size_bad, xfer_err, retry_hit;
  logic               accept, start_ok, wr_commit, rd_en;
  logic [AW-1:0]      req_idx;
  logic [NB-1:0]      req_mask, bank_we;
  logic [BUS_WDT-1:0] ram_rdata;
  hresp_e             hresp_int;

`ifdef AHB_SLAVE_RETRY_EN
  assign retry_hit = i_retry_req;
  logic unused_sigs;
  assign unused_sigs = ^i_hburst;
`else
  assign retry_hit = 1'b0;
  logic unused_sigs;
  assign unused_sigs = ^{i_hburst, i_retry_req};
`endif

  // Address-phase decode: range, alignment and size checks plus lane mask.
  always_comb begin
    // The borrow bit lands in bit 32 for addresses below the base.
    rel_addr = {1'b0, i_haddr} - {1'b0, BASE_ADDR};
    case (i_hsize)
      2'd1:    misaligned = i_haddr[0];
      2'd2:    misaligned = |i_haddr[1:0];
      2'd3:    misaligned = |i_haddr[2:0];
      default: misaligned = 1'b0;
    endcase
    size_bad = (i_hsize == 2'd3) && (BUS_WDT == 32);
    xfer_err = (rel_addr >= MEM_BYTES) || misaligned || size_bad;
    req_idx  = rel_addr[OFFW +: AW];
    req_mask = NB'(size_lane_bits(i_hsize)) << i_haddr[OFFW-1:0];
  end

  assign accept    = i_hready && o_hready && i_hsel && i_htrans[1];
  assign start_ok  = accept && !xfer_err && !retry_hit;
  assign wr_commit = (state_q == ST_DATA) && write_q && !i_hreset;
  assign bank_we   = wr_commit ? mask_q : '0;

  // Next state plus captured address-phase attributes and read bypass.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_idx_d = addr_idx_q;
    mask_d     = mask_q;
    write_d    = write_q;
    byp_mask_d = byp_mask_q;
    byp_data_d = byp_data_q;
    rd_en      = 1'b0;

    case (state_q)
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
`ifdef AHB_SLAVE_RETRY_EN
      ST_RTY1: state_d = ST_RTY2;
`endif
      // IDLE, DATA, ERR2 and RTY2 all drive hready high and may take a new
      // address phase, which is what allows pipelined back-to-back transfers.
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (xfer_err) begin
            state_d = ST_ERR1;
          end else if (retry_hit) begin
`ifdef AHB_SLAVE_RETRY_EN
            state_d = ST_RTY1;
`endif
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = 4'(WAIT_STATES);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase

    if (start_ok) begin
      addr_idx_d = req_idx;
      mask_d     = req_mask;
      write_d    = i_hwrite;
      if (!i_hwrite) begin
        rd_en      = 1'b1;
        // A write committing this edge to the same word is not yet visible
        // in the RAM read, so its lanes are overlaid from the write data.
        byp_mask_d = (wr_commit && (addr_idx_q == req_idx)) ? mask_q : '0;
        byp_data_d = i_hwdata;
      end
    end
  end

  // State and captured-attribute registers.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      addr_idx_q <= '0;
      mask_q     <= '0;
      write_q    <= 1'b0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_idx_q <= addr_idx_d;
      mask_q     <= mask_d;
      write_q    <= write_d;
      byp_mask_q <= byp_mask_d;
      byp_data_q <= byp_data_d;
    end
  end

  // Bus response decoded from the current state.
  always_comb begin
    o_hready  = 1'b1;
    hresp_int = HRESP_OKAY;
    case (state_q)
      ST_WAIT: o_hready = 1'b0;
      ST_ERR1: begin
        o_hready  = 1'b0;
        hresp_int = HRESP_ERROR;
      end
      ST_ERR2: hresp_int = HRESP_ERROR;
`ifdef AHB_SLAVE_RETRY_EN
      ST_RTY1: begin
        o_hready  = 1'b0;
        hresp_int = HRESP_RETRY;
      end
      ST_RTY2: hresp_int = HRESP_RETRY;
`endif
      default: ;
    endcase
  end

  // Read data: RAM capture with bypassed lanes overlaid.
  always_comb begin
    o_hrdata = ram_rdata;
    for (int b = 0; b < NB; b++) begin
      if (byp_mask_q[b]) o_hrdata[8*b +: 8] = byp_data_q[8*b +: 8];
    end
  end

  assign o_hresp     = hresp_int;
  assign o_dbg_state = state_q;

  ahb_sram_bank #(
    .BUS_WDT (BUS_WDT),
    .DEPTH   (DEPTH)
  ) u_bank (
    .clk   (i_hclk),
    .rst   (i_hreset),
    .we    (bank_we),
    .waddr (addr_idx_q),
    .wdata (i_hwdata),
    .re    (rd_en),
    .raddr (req_idx),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_ahb_slave_sram.sv
// Directed bench for ahb_slave_sram: one zero-wait and one two-wait slave
// share a bus; cur selects which slave owns hsel and global HREADY.
module tb_ahb_slave_sram;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel_bus;
  logic [31:0] haddr;
  logic [1:0]  htrans, hsize, hburst;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        retry_req;
  int          cur;
  logic [2:0]  dbg0, dbg2;
  logic        bus_hready;
  logic [1:0]  hresp_cur;
  logic [31:0] hrdata_cur;
  logic [31:0] wd [4];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          total;

  ahb_slave_sram_if #(.BUS_WDT(32)) bus0 ();
  ahb_slave_sram_if #(.BUS_WDT(32)) bus2 ();

  // clock and reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign bus_hready = (cur == 2) ? bus2.hready_out : bus0.hready_out;
  assign hresp_cur  = (cur == 2) ? bus2.hresp : bus0.hresp;
  assign hrdata_cur = (cur == 2) ? bus2.hrdata : bus0.hrdata;

  assign bus0.hsel = hsel_bus && (cur == 0);
  assign bus2.hsel = hsel_bus && (cur == 2);
  assign bus0.haddr = haddr;      assign bus2.haddr = haddr;
  assign bus0.htrans = htrans;    assign bus2.htrans = htrans;
  assign bus0.hwrite = hwrite;    assign bus2.hwrite = hwrite;
  assign bus0.hsize = hsize;      assign bus2.hsize = hsize;
  assign bus0.hburst = hburst;    assign bus2.hburst = hburst;
  assign bus0.hwdata = hwdata;    assign bus2.hwdata = hwdata;
  assign bus0.hready = bus_hready; assign bus2.hready = bus_hready;
  assign bus0.retry_req = retry_req; assign bus2.retry_req = retry_req;

  ahb_slave_sram #(.BUS_WDT(32), .DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .i_hclk(clk), .i_hreset(rst), .i_hsel(bus0.hsel), .i_haddr(bus0.haddr),
    .i_htrans(bus0.htrans), .i_hwrite(bus0.hwrite), .i_hsize(bus0.hsize),
    .i_hburst(bus0.hburst), .i_hwdata(bus0.hwdata), .i_hready(bus0.hready),
    .i_retry_req(bus0.retry_req), .o_hready(bus0.hready_out), .o_hresp(bus0.hresp),
    .o_hrdata(bus0.hrdata), .o_dbg_state(dbg0)
  );

  ahb_slave_sram #(.BUS_WDT(32), .DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut2 (
    .i_hclk(clk), .i_hreset(rst), .i_hsel(bus2.hsel), .i_haddr(bus2.haddr),
    .i_htrans(bus2.htrans), .i_hwrite(bus2.hwrite), .i_hsize(bus2.hsize),
    .i_hburst(bus2.hburst), .i_hwdata(bus2.hwdata), .i_hready(bus2.hready),
    .i_retry_req(bus2.retry_req), .o_hready(bus2.hready_out), .o_hresp(bus2.hresp),
    .o_hrdata(bus2.hrdata), .o_dbg_state(dbg2)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [1:0] tr, input logic [31:0] a,
                            input logic wr, input logic [1:0] sz);
    hsel_bus = 1'b1;
    htrans   = tr;
    haddr    = a;
    hwrite   = wr;
    hsize    = sz;
    hburst   = HBURST_INCR;
  endtask

  task automatic idle_phase();
    hsel_bus = 1'b0;
    htrans   = HTRANS_IDLE;
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word burst on the current slave. Each beat's data-phase length is
  // measured (bounded) and compared; reads are checked against wd[].
  task automatic burst(input string tag, input logic wr, input logic [31:0] a0,
                       input int n, input int beat_cyc, output int tot);
    int cyc;
    tot = 0;
    addr_phase(HTRANS_NONSEQ, a0, wr, 2'd2);
    for (int b = 0; b < n; b++) begin
      tick();
      if (b + 1 < n) addr_phase(HTRANS_SEQ, a0 + 32'(4 * (b + 1)), wr, 2'd2);
      else           idle_phase();
      if (wr) hwdata = wd[b];
      cyc = 1;
      while (bus_hready !== 1'b1 && cyc < 32) begin
        tick();
        cyc++;
      end
      chk({tag, " beat cycles"}, 64'(cyc), 64'(beat_cyc));
      chk({tag, " hresp"}, 64'(hresp_cur), 64'(HRESP_OKAY));
      if (!wr) chk({tag, " rdata"}, 64'(hrdata_cur), 64'(wd[b]));
      tot += cyc;
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; hsel_bus = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0;
    hsize = 2'd2; hburst = HBURST_SINGLE; hwdata = '0; retry_req = 1'b0; cur = 0;
    tick();
    tick();
    chk("rst hready0", 64'(bus0.hready_out), 64'd1);
    chk("rst hresp0", 64'(bus0.hresp), 64'(HRESP_OKAY));
    chk("rst hrdata0", 64'(bus0.hrdata), 64'd0);
    chk("rst state0", 64'(dbg0), 64'(ST_IDLE));
    chk("rst hready2", 64'(bus2.hready_out), 64'd1);
    chk("rst hrdata2", 64'(bus2.hrdata), 64'd0);
    rst = 1'b0;

    // zero-wait write then back-to-back read of the same word (bypass)
    addr_phase(HTRANS_NONSEQ, 32'h10, 1'b1, 2'd2);
    tick();
    hwdata = 32'hDEAD_BEEF;
    addr_phase(HTRANS_NONSEQ, 32'h10, 1'b0, 2'd2);
    tick();
    chk("b2b hready", 64'(bus_hready), 64'd1);
    chk("b2b hresp", 64'(hresp_cur), 64'(HRESP_OKAY));
    chk("b2b rdata", 64'(hrdata_cur), 64'hDEAD_BEEF);
    chk("b2b state", 64'(dbg0), 64'(ST_DATA));
    idle_phase();
    tick();
    chk("b2b idle", 64'(dbg0), 64'(ST_IDLE));
    wd[0] = 32'hDEAD_BEEF;
    burst("rd 0x10", 1'b0, 32'h10, 1, 1, total);

    // byte write merged into a word, read back via bypass and from RAM
    addr_phase(HTRANS_NONSEQ, 32'h20, 1'b1, 2'd2);
    tick();
    hwdata = 32'h1122_3344;
    addr_phase(HTRANS_NONSEQ, 32'h21, 1'b1, 2'd0);
    tick();
    hwdata = 32'h0000_AA00;
    addr_phase(HTRANS_NONSEQ, 32'h20, 1'b0, 2'd2);
    tick();
    chk("byte merge bypass", 64'(hrdata_cur), 64'h1122_AA44);
    idle_phase();
    tick();
    addr_phase(HTRANS_NONSEQ, 32'h22, 1'b0, 2'd1);
    tick();
    idle_phase();
    chk("half read lanes", 64'(hrdata_cur), 64'h1122_AA44);
    tick();

    // misaligned word read: ERR1 then ERR2 then idle
    addr_phase(HTRANS_NONSEQ, 32'h22, 1'b0, 2'd2);
    tick();
    chk("misalign err1 hready", 64'(bus_hready), 64'd0);
    chk("misalign err1 hresp", 64'(hresp_cur), 64'(HRESP_ERROR));
    idle_phase();
    tick();
    chk("misalign err2 hready", 64'(bus_hready), 64'd1);
    chk("misalign err2 hresp", 64'(hresp_cur), 64'(HRESP_ERROR));
    tick();
    chk("misalign after hresp", 64'(hresp_cur), 64'(HRESP_OKAY));

    // misaligned write that would alias word 4 must not land
    addr_phase(HTRANS_NONSEQ, 32'h12, 1'b1, 2'd2);
    tick();
    chk("misalign wr hresp", 64'(hresp_cur), 64'(HRESP_ERROR));
    idle_phase();
    hwdata = 32'h5555_5555;
    tick();
    tick();

    // out-of-range write (wraps to word 4), new read accepted in ERR2
    addr_phase(HTRANS_NONSEQ, 32'h1010, 1'b1, 2'd2);
    tick();
    chk("range err1 hready", 64'(bus_hready), 64'd0);
    chk("range err1 hresp", 64'(hresp_cur), 64'(HRESP_ERROR));
    idle_phase();
    hwdata = 32'h1234_5678;
    tick();
    chk("range err2 hresp", 64'(hresp_cur), 64'(HRESP_ERROR));
    addr_phase(HTRANS_NONSEQ, 32'h10, 1'b0, 2'd2);
    tick();
    chk("err2 pipelined hready", 64'(bus_hready), 64'd1);
    chk("err2 pipelined hresp", 64'(hresp_cur), 64'(HRESP_OKAY));
    chk("err2 pipelined rdata", 64'(hrdata_cur), 64'hDEAD_BEEF);
    idle_phase();
    tick();

    // dword on a 32-bit bus; a write presented during ERR1 is ignored
    addr_phase(HTRANS_NONSEQ, 32'h18, 1'b0, 2'd3);
    tick();
    chk("dword err1 hresp", 64'(hresp_cur), 64'(HRESP_ERROR));
    addr_phase(HTRANS_NONSEQ, 32'h10, 1'b1, 2'd2);
    tick();
    chk("dword err2 hresp", 64'(hresp_cur), 64'(HRESP_ERROR));
    idle_phase();
    hwdata = 32'h9999_9999;
    tick();
    chk("err1 addr ignored", 64'(dbg0), 64'(ST_IDLE));
    wd[0] = 32'hDEAD_BEEF;
    burst("rd after errors", 1'b0, 32'h10, 1, 1, total);

    // two-wait slave: 4-beat INCR write then read, 3 cycles per beat
    cur = 2;
    wd[0] = 32'hA5A5_0000; wd[1] = 32'hA5A5_0001;
    wd[2] = 32'hA5A5_0002; wd[3] = 32'hA5A5_0003;
    burst("ws2 wr", 1'b1, 32'h0, 4, 3, total);
    burst("ws2 rd", 1'b0, 32'h0, 4, 3, total);
    chk("ws2 rd total cycles", 64'(total), 64'd12);

    // reset during WAIT of a write aborts it
    addr_phase(HTRANS_NONSEQ, 32'h4, 1'b1, 2'd2);
    tick();
    chk("rst-wait in wait", 64'(dbg2), 64'(ST_WAIT));
    idle_phase();
    hwdata = 32'hCAFE_F00D;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst-wait hready", 64'(bus_hready), 64'd1);
    chk("rst-wait hresp", 64'(hresp_cur), 64'(HRESP_OKAY));
    chk("rst-wait hrdata", 64'(hrdata_cur), 64'd0);
    wd[0] = 32'hA5A5_0001;
    burst("rst-wait word", 1'b0, 32'h4, 1, 3, total);

    // retry request on a write to 0x30
    cur = 0;
    wd[0] = 32'h1111_1111;
    burst("pre 0x30", 1'b1, 32'h30, 1, 1, total);
    retry_req = 1'b1;
    addr_phase(HTRANS_NONSEQ, 32'h30, 1'b1, 2'd2);
    tick();
    retry_req = 1'b0;
`ifdef AHB_SLAVE_RETRY_EN
    chk("rty1 hready", 64'(bus_hready), 64'd0);
    chk("rty1 hresp", 64'(hresp_cur), 64'(HRESP_RETRY));
    idle_phase();
    hwdata = 32'h0BAD_F00D;
    tick();
    chk("rty2 hready", 64'(bus_hready), 64'd1);
    chk("rty2 hresp", 64'(hresp_cur), 64'(HRESP_RETRY));
    tick();
    chk("rty done hresp", 64'(hresp_cur), 64'(HRESP_OKAY));
    burst("rty no write", 1'b0, 32'h30, 1, 1, total);
    wd[0] = 32'h0BAD_F00D;
    burst("rty0 write", 1'b1, 32'h30, 1, 1, total);
    burst("rty0 readback", 1'b0, 32'h30, 1, 1, total);
`else
    chk("retry ignored hready", 64'(bus_hready), 64'd1);
    chk("retry ignored hresp", 64'(hresp_cur), 64'(HRESP_OKAY));
    idle_phase();
    hwdata = 32'h0BAD_F00D;
    tick();
    wd[0] = 32'h0BAD_F00D;
    burst("retry ignored rd", 1'b0, 32'h30, 1, 1, total);
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_slave_sram.md
Name: ahb_slave_sram

Overview:
AHB responder that terminates transfers issued by the team's AHB master into an on-chip byte-addressable SRAM.
- Supports configurable wait states, SINGLE/INCR bursts, byte/halfword/word/dword sizes and two-cycle ERROR responses.
- Optionally supports two-cycle RETRY responses.
- Sits behind the address decoder and the hready/hrdata mux as a standard bus slave.

Parameters:
BUS_WDT, 32, data bus width; 32 or 64.
DEPTH, 1024, memory depth in BUS_WDT-bit words; power of two.
BASE_ADDR, 32'h0000_0000, byte base address; must be aligned to DEPTH*BUS_WDT/8.
WAIT_STATES, 0, wait cycles inserted per data phase (0-15).

Ports:
i_hclk  in  1  bus clock, rising edge.
i_hreset  in  1  synchronous, active-high reset.
i_hsel  in  1  slave select from decoder.
i_haddr  in  32  address.
i_htrans  in  2  IDLE/BUSY/NONSEQ/SEQ.
i_hwrite  in  1  1 = write.
i_hsize  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
i_hburst  in  2  burst type; accepted, no effect on behaviour.
i_hwdata  in  BUS_WDT  write data, data phase.
i_hready  in  1  global HREADY from the bus mux.
i_retry_req  in  1  request RETRY on the next accepted transfer; used only with the macro.
o_hready  out  1  slave ready.
o_hresp  out  2  OKAY = 0, ERROR = 1, RETRY = 2.
o_hrdata  out  BUS_WDT  read data, little-endian lanes.

Behaviour:
- Reset (synchronous on i_hclk when i_hreset = 1):
  - state to IDLE; o_hready = 1, o_hresp = OKAY, o_hrdata = 0, wait counter = 0.
  - Memory contents are not cleared.
  - Reset mid-transfer aborts it with no memory write.
- Address phase accepted on an edge where i_hready & i_hsel & i_htrans[1]. At acceptance, register addr, size, write and lane mask.
- Transfers with IDLE/BUSY or i_hsel = 0 produce a zero-wait OKAY; no access.
- Error check at acceptance:
  - addr outside [BASE_ADDR, BASE_ADDR + DEPTH*BUS_WDT/8);
  - addr not aligned to 2^hsize;
  - hsize = 3 with BUS_WDT = 32.
  - Any of these gives ERROR.
- FSM states:
  - IDLE: o_hready = 1, OKAY. Go to WAIT if accepted with no error and WAIT_STATES > 0. Go to DATA if accepted with no error and WAIT_STATES = 0. Go to ERR1 on error.
  - WAIT: o_hready = 0, OKAY. Counter runs WAIT_STATES down to 1, then DATA.
  - DATA: o_hready = 1, OKAY; the access completes on this edge.
    - Write: commits the byte lanes from i_hwdata.
    - Next state follows IDLE rules, so back-to-back pipelined transfers are allowed.
  - ERR1: o_hready = 0, o_hresp = ERROR, then ERR2.
  - ERR2: o_hready = 1, o_hresp = ERROR. A new address phase is accepted here per IDLE rules. The address phase presented during ERR1 is ignored because i_hready = 0.
  - RTY1/RTY2: as ERR1/ERR2 with o_hresp = RETRY (macro only).
- WAIT_STATES = 0: a single-cycle data phase; state stays DATA across back-to-back transfers.
- Reads:
  - Memory read at the accepting edge into o_hrdata, so data is valid throughout the data phase and stable through wait states.
  - Unselected lanes carry memory contents.
  - o_hrdata is held otherwise.
- Read-after-write hazard: a read accepted on the same edge that commits a write to the same word returns the merged data. Written lanes come from i_hwdata; the other lanes come from memory.
- Lane mask: the (2^hsize)-byte lane set at offset addr[log2(BUS_WDT/8)-1:0].
- Word index = (addr - BASE_ADDR) >> log2(BUS_WDT/8), width log2(DEPTH).
- No write on ERROR or RETRY.
- Wait states and response sequences are never aborted by the bus; the FSM always completes them.

Optional Feature:
AHB_SLAVE_RETRY_EN:
- Defined: if i_retry_req = 1 at acceptance of an error-free transfer, go to RTY1 then RTY2, with no access. Error has priority over retry.
- Undefined: i_retry_req is ignored, the RTY states are absent, and RETRY is never driven.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ);
  - HRESP codes (OKAY/ERROR/RETRY/SPLIT);
  - HBURST INCR;
  - HSIZE codes;
  - slave FSM state encoding.
- One sub-module, ahb_sram_bank: a DEPTH x BUS_WDT RAM with per-byte write enables and a synchronous read port. The read-after-write bypass merge sits in the parent.

Test Plan:
- WAIT_STATES = 0: NONSEQ write word 0xDEADBEEF @0x10, then NONSEQ read @0x10 back-to-back -> read data phase o_hready = 1, OKAY, o_hrdata = 0xDEADBEEF (bypass path).
- WAIT_STATES = 2: INCR burst of 4 word reads @0x0 (NONSEQ, SEQ x3) -> each data phase shows o_hready low 2 cycles then high with correct data; total 12 data-phase cycles.
- Byte write 0xAA @0x21 over word 0x11223344 @0x20, then word read @0x20 -> 0x1122AA44.
- Word access @0x22 (misaligned) and access @BASE_ADDR + DEPTH*4 -> each gives ERR1 (hready 0, ERROR) then ERR2 (hready 1, ERROR); memory unchanged.
- Assert i_hreset during WAIT of a write -> next cycle o_hready = 1, OKAY, o_hrdata = 0; target word unchanged.
- Macro defined, i_retry_req = 1 on write @0x30 -> RETRY two-cycle response, no write; repeat with i_retry_req = 0 -> OKAY, write lands.
